delay_line: RTL

- Runtime-programmable delay line on inferred simple-dual-port block RAM; generalises the fixed-length BRAM shift register.
- Delays a sample stream by len samples (not cycles): only accepted samples advance the line.
- Optional RAM clear on reset and length change, so the fill phase outputs zeros rather than stale data.
- Used in front of FFT/correlator paths that need a configurable sample-aligned delay.

---
 rtl/delay_line_pkg.sv | 35 +++
 rtl/delay_line_ram.sv | 44 ++++
 rtl/delay_line.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/delay_line_pkg.sv
// delay_line_pkg
// Shared types and helpers for the programmable sample delay line.
//   state_t    : control FSM states (CLEAR, FILL, RUN)
//   len_width  : bit width needed to hold a delay length 0..max_len
//   addr_width : RAM address width for a given depth (at least 1 bit)
//   clamp_len  : maps a requested length onto the legal range 1..max_len
package delay_line_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2
   } state_t;

   function automatic int len_width(input int unsigned max_len);
      return $clog2(max_len + 32'd1);
   endfunction

   function automatic int addr_width(input int unsigned depth);
      return (depth > 32'd1) ? $clog2(depth) : 32'sd1;
   endfunction

   function automatic int unsigned clamp_len(input int unsigned req, input int unsigned max_len);
      int unsigned len_s;
      if (req == 32'd0) begin
         len_s = 32'd1;
      end else if (req > max_len) begin
         len_s = max_len;
      end else begin
         len_s = req;
      end
      return len_s;
   endfunction

endpackage

// File: rtl/delay_line_ram.sv
// delay_line_ram
// Inferred simple-dual-port RAM, single clock, read-first, one cycle read
// latency with no extra output pipeline stage. The read latch has a
// synchronous reset so the delay line output comes up as zero.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset of the read latch
//   we, waddr, wdata: write port
//   re, raddr       : read enable and address
//   rdata           : registered read data (holds when re=0)
module delay_line_ram
   import delay_line_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 25,
   parameter int unsigned DEPTH      = 512
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          we,
   input  logic [addr_width(DEPTH)-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0]         wdata,
   input  logic                          re,
   input  logic [addr_width(DEPTH)-1:0]  raddr,
   output logic [DATA_WIDTH-1:0]         rdata
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read port; the non-blocking read sees the pre-write contents (read-first)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/delay_line.sv
// delay_line
// Runtime-programmable delay line: each accepted sample is written into a
// circular buffer of len_q entries while the entry it overwrites (written
// len_q accepted samples earlier) is read out. Optionally the used part of
// the RAM is zeroed after reset and after each length load.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   len_i      : requested delay in samples (0 -> 1, >MAX_LEN -> MAX_LEN)
//   len_load   : strobe, latch len_i and flush the line
//   valid_i, di: input sample stream (accepted when ready_o=1)
//   ready_o    : line accepting samples
//   valid_o    : data_o valid, one cycle after each accepted sample
//   data_o     : sample accepted len samples earlier
//   primed_o   : line full, data_o is a true delayed sample
module delay_line
   import delay_line_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 25,
   parameter int unsigned MAX_LEN       = 512,
   parameter bit          CLEAR_ON_LOAD = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [len_width(MAX_LEN)-1:0] len_i,
   input  logic                          len_load,
   input  logic                          valid_i,
   input  logic [DATA_WIDTH-1:0]         di,
   output logic                          ready_o,
   output logic                          valid_o,
   output logic [DATA_WIDTH-1:0]         data_o,
   output logic                          primed_o
);

   localparam int     LW         = len_width(MAX_LEN);
   localparam int     AW         = addr_width(MAX_LEN);
   localparam state_t LOAD_STATE = (CLEAR_ON_LOAD == 1'b1) ? CLEAR : FILL;

   state_t          state_r, state_next_s;
   logic [LW-1:0]   len_q_r, len_next_s, len_clamp_s;
   logic [LW-1:0]   ptr_r, ptr_next_s;
   logic [LW-1:0]   fill_r, fill_next_s;
   logic            ready_r, ready_next_s;
   logic            valid_r;
   logic            primed_r, primed_next_s;
   logic            accept_s;
   logic            ptr_last_s;
   logic            wr_en_s;
   logic [DATA_WIDTH-1:0] wr_data_s;

   assign len_clamp_s = LW'(clamp_len(32'(len_i), MAX_LEN));
   // A length load in the same cycle wins over the sample
   assign accept_s    = valid_i & ready_r & ~len_load;
   assign ptr_last_s  = (ptr_r == (len_q_r - LW'(1)));

   // Next-state and next-value logic for the control path
   always_comb begin
      state_next_s  = state_r;
      len_next_s    = len_q_r;
      ptr_next_s    = ptr_r;
      fill_next_s   = fill_r;
      ready_next_s  = ready_r;
      primed_next_s = primed_r;
      wr_en_s       = 1'b0;
      wr_data_s     = '0;
      if (len_load) begin
         len_next_s    = len_clamp_s;
         ptr_next_s    = '0;
         fill_next_s   = '0;
         primed_next_s = 1'b0;
         ready_next_s  = 1'b0;
         state_next_s  = LOAD_STATE;
      end else begin
         case (state_r)
            CLEAR: begin
               wr_en_s      = 1'b1;
               ready_next_s = ptr_last_s;
               if (ptr_last_s) begin
                  ptr_next_s   = '0;
                  state_next_s = FILL;
               end else begin
                  ptr_next_s   = ptr_r + LW'(1);
               end
            end
            FILL, RUN: begin
               ready_next_s = 1'b1;
               if (accept_s) begin
                  wr_en_s    = 1'b1;
                  wr_data_s  = di;
                  ptr_next_s = ptr_last_s ? '0 : (ptr_r + LW'(1));
                  if (state_r == FILL) begin
                     fill_next_s  = fill_r + LW'(1);
                     state_next_s = (fill_next_s == len_q_r) ? RUN : FILL;
                  end else begin
                     primed_next_s = 1'b1;
                  end
               end else begin
                  wr_en_s = 1'b0;
               end
            end
            default: begin
               ptr_next_s    = '0;
               fill_next_s   = '0;
               primed_next_s = 1'b0;
               ready_next_s  = 1'b0;
               state_next_s  = LOAD_STATE;
            end
         endcase
      end
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= LOAD_STATE;
         len_q_r  <= LW'(MAX_LEN);
         ptr_r    <= '0;
         fill_r   <= '0;
         ready_r  <= 1'b0;
         valid_r  <= 1'b0;
         primed_r <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         len_q_r  <= len_next_s;
         ptr_r    <= ptr_next_s;
         fill_r   <= fill_next_s;
         ready_r  <= ready_next_s;
         valid_r  <= accept_s;
         primed_r <= primed_next_s;
      end
   end

   // Writes are suppressed while reset is asserted so a reset cycle never
   // disturbs RAM contents
   delay_line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_LEN)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en_s & rst_n),
      .waddr (ptr_r[AW-1:0]),
      .wdata (wr_data_s),
      .re    (accept_s),
      .raddr (ptr_r[AW-1:0]),
      .rdata (data_o)
   );

   assign ready_o  = ready_r;
   assign valid_o  = valid_r;
   assign primed_o = primed_r;

endmodule
